// File: rtl/reg_mem_xfer.sv
// Register bank plus local memory with a sequenced LOAD/STORE/CLEAR transfer engine.
// Start/Busy/Done/Err handshake; all registers exposed on q_o.
module reg_mem_xfer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREGS = 2,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned RW = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [RW-1:0]          reg_sel_i,
    input  logic [AW-1:0]          addr_i,
    input  logic [RW:0]            len_i,
    input  logic                   ext_we_i,
    input  logic [AW-1:0]          ext_addr_i,
    input  logic [WIDTH-1:0]       ext_data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o,
    output logic [NREGS*WIDTH-1:0] q_o
);

    localparam int unsigned LW = RW + 1;
    localparam int unsigned SW = RW + 2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_RSV   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WB   = 3'd2,
        S_WR   = 3'd3,
        S_CLR  = 3'd4
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] mem_q  [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [AW-1:0]    addr_q;
    logic [RW-1:0]    cur_q;
    logic [LW-1:0]    rem_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic [AW-1:0]    addr_d;
    logic [RW-1:0]    cur_d;
    logic [LW-1:0]    rem_d;
    logic [SW-1:0]    span_c;
    logic             cmd_ok_c;
    logic             last_c;

    // Command validation and per-word advance values.
    always_comb begin
        span_c   = SW'(reg_sel_i) + SW'(len_i);
        cmd_ok_c = (op_i != OP_RSV) && (len_i != '0) && (span_c <= SW'(NREGS));
        addr_d   = addr_q + AW'(1);
        cur_d    = cur_q + RW'(1);
        rem_d    = rem_q - LW'(1);
        last_c   = (rem_q == LW'(1));
    end

    always_comb begin
        q_o = '0;
        for (int i = 0; i < int'(NREGS); i++) begin
            q_o[i*WIDTH +: WIDTH] = regs_q[i];
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

    // Engine, register bank and memory share one sequential process.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
            addr_q  <= '0;
            cur_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ext_we_i) begin
                        mem_q[ext_addr_i] <= ext_data_i;
                    end
                    if (start_i) begin
                        if (!cmd_ok_c) begin
                            err_q <= 1'b1;
                        end else begin
                            addr_q <= addr_i;
                            cur_q  <= reg_sel_i;
                            rem_q  <= len_i;
                            busy_q <= 1'b1;
                            case (op_i)
                                OP_LOAD:  state_q <= S_RD;
                                OP_STORE: state_q <= S_WR;
                                default:  state_q <= S_CLR;
                            endcase
                        end
                    end
                end
                S_RD: begin
                    rdata_q <= mem_q[addr_q];
                    state_q <= S_WB;
                end
                S_WB, S_WR, S_CLR: begin
                    if (state_q == S_WB) begin
                        regs_q[cur_q] <= rdata_q;
                    end else if (state_q == S_WR) begin
                        mem_q[addr_q] <= regs_q[cur_q];
                    end else begin
                        regs_q[cur_q] <= '0;
                    end
                    if (last_c) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        addr_q <= addr_d;
                        cur_q  <= cur_d;
                        rem_q  <= rem_d;
                        if (state_q == S_WB) begin
                            state_q <= S_RD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_mem_xfer.sv
// Scoreboard bench for reg_mem_xfer: a word-level command model predicts each
// Done/Err response, its cycle and Q; a monitor checks responses as they appear.
module tb_reg_mem_xfer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [1:0]  reg_sel_i;
    logic [3:0]  addr_i;
    logic [2:0]  len_i;
    logic        ext_we_i;
    logic [3:0]  ext_addr_i;
    logic [7:0]  ext_data_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] q_o;

    reg_mem_xfer #(.WIDTH(8), .NREGS(4), .DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .reg_sel_i  (reg_sel_i),
        .addr_i     (addr_i),
        .len_i      (len_i),
        .ext_we_i   (ext_we_i),
        .ext_addr_i (ext_addr_i),
        .ext_data_i (ext_data_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .q_o        (q_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [31:0] q;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [7:0] mem_m [16];
    logic [7:0] reg_m [4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack_regs();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = reg_m[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
        for (int i = 0; i < 4; i++) reg_m[i] = 8'h00;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL busy_timeout: busy still 1 after %0d cycles", guard);
        end
    endtask

    // Issue one command (optionally with a same-cycle external write) and predict its outcome.
    task automatic issue(input logic [1:0] op, input int rs, input int a, input int len,
                         input bit ext, input int ea, input int ed, output int acc);
        exp_t e;
        @(negedge clk);
        wait_idle();
        start_i    = 1'b1;
        op_i       = op;
        reg_sel_i  = 2'(rs);
        addr_i     = 4'(a);
        len_i      = 3'(len);
        ext_we_i   = ext;
        ext_addr_i = 4'(ea);
        ext_data_i = 8'(ed);
        acc = cyc + 1;
        if (ext) mem_m[ea] = 8'(ed);
        if (op == 2'b11 || len == 0 || rs + len > 4) begin
            e.is_err = 1'b1;
            e.cyc    = acc;
        end else begin
            e.is_err = 1'b0;
            for (int i = 0; i < len; i++) begin
                case (op)
                    2'b00:   reg_m[rs+i] = mem_m[(a+i) % 16];
                    2'b01:   mem_m[(a+i) % 16] = reg_m[rs+i];
                    default: reg_m[rs+i] = 8'h00;
                endcase
            end
            e.cyc = acc + ((op == 2'b00) ? 2*len : len);
        end
        e.q = pack_regs();
        exp_q.push_back(e);
        @(negedge clk);
        start_i  = 1'b0;
        ext_we_i = 1'b0;
    endtask

    task automatic ext_write(input int a, input int d);
        @(negedge clk);
        wait_idle();
        ext_we_i   = 1'b1;
        ext_addr_i = 4'(a);
        ext_data_i = 8'(d);
        mem_m[a]   = 8'(d);
        @(negedge clk);
        ext_we_i = 1'b0;
    endtask

    // External write while the engine is busy: the model expects it to be dropped.
    task automatic ext_write_busy(input int a, input int d);
        ext_we_i   = 1'b1;
        ext_addr_i = 4'(a);
        ext_data_i = 8'(d);
        @(negedge clk);
        ext_we_i = 1'b0;
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done_o || err_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious: done=%0b err=%0b with no command pending (cycle %0d)",
                             done_o, err_o, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("kind{done,err}", 32'({done_o, err_o}), mon_e.is_err ? 32'd1 : 32'd2);
                    check("latency", 32'(cyc), 32'(mon_e.cyc));
                    check("q", q_o, mon_e.q);
                    check("busy_at_resp", 32'(busy_o), 32'd0);
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_resp: no done/err by cycle %0d expected at %0d", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int acc, acc_s, acc_c, guard;
        rst_n = 1'b0;
        start_i = 1'b0; op_i = 2'b00; reg_sel_i = '0; addr_i = '0; len_i = '0;
        ext_we_i = 1'b0; ext_addr_i = '0; ext_data_i = '0;
        model_reset();
        #3;
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_err",  32'(err_o),  32'd0);
        check("rst_q",    q_o,         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Preloaded burst into registers 1..3.
        ext_write(5, 8'h11);
        ext_write(6, 8'h22);
        ext_write(7, 8'h33);
        issue(2'b00, 1, 5, 3, 1'b0, 0, 0, acc);

        // Memory address wraps 15 -> 0.
        ext_write(15, 8'hAA);
        ext_write(0, 8'hBB);
        issue(2'b00, 0, 15, 2, 1'b0, 0, 0, acc);

        // Reset in the middle of a LOAD burst.
        ext_write(3, 8'h5A);
        issue(2'b00, 0, 3, 4, 1'b0, 0, 0, acc);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_q",    q_o,         32'd0);
        exp_q.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 0, 3, 1, 1'b0, 0, 0, acc);

        // STORE/CLEAR/LOAD round trip of 01..04.
        for (int i = 0; i < 4; i++) ext_write(12 + i, i + 1);
        issue(2'b00, 0, 12, 4, 1'b0, 0, 0, acc);
        issue(2'b01, 0, 8, 4, 1'b0, 0, 0, acc);
        issue(2'b10, 0, 0, 4, 1'b0, 0, 0, acc);
        issue(2'b00, 0, 8, 4, 1'b0, 0, 0, acc);

        // Rejected commands.
        issue(2'b00, 0, 0, 0, 1'b0, 0, 0, acc);
        issue(2'b11, 0, 0, 1, 1'b0, 0, 0, acc);
        issue(2'b00, 3, 0, 2, 1'b0, 0, 0, acc);
        issue(2'b01, 2, 9, 4, 1'b0, 0, 0, acc);
        issue(2'b00, 0, 8, 4, 1'b0, 0, 0, acc);

        // Ext write with STORE to same address; CLEAR back-to-back on Done; busy ext write dropped.
        issue(2'b01, 0, 4, 2, 1'b1, 4, 8'hEE, acc_s);
        issue(2'b10, 2, 0, 2, 1'b0, 0, 0, acc_c);
        check("back_to_back_accept", 32'(acc_c), 32'(acc_s + 3));
        ext_write_busy(5, 8'h77);
        issue(2'b00, 0, 4, 2, 1'b0, 0, 0, acc);

        // Randomized command mix.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) ext_write($urandom_range(0, 15), $urandom_range(0, 255));
            issue(2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                  $urandom_range(0, 255), acc);
        end

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d responses never arrived", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
